// File: rtl/regfile_sweep_if.sv
// rtl/regfile_sweep_if.sv - read/write port bundle for regfile_sweep
// Optional scoreboard signals appear when REGFILE_SCOREBOARD_EN is defined.
interface regfile_sweep_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rsaddr_i;
    logic [ADDR_W-1:0] rtaddr_i;
    logic [DATA_W-1:0] rsdata_o;
    logic [DATA_W-1:0] rtdata_o;
    logic              regwrite_i;
    logic [ADDR_W-1:0] writeaddr_i;
    logic [DATA_W-1:0] writedata_i;
`ifdef REGFILE_SCOREBOARD_EN
    logic              alloc_i;
    logic [ADDR_W-1:0] allocaddr_i;
    logic              rs_pending_o;
    logic              rt_pending_o;
`endif

`ifdef REGFILE_SCOREBOARD_EN
    modport master (
        output rsaddr_i, rtaddr_i, regwrite_i, writeaddr_i, writedata_i,
        output alloc_i, allocaddr_i,
        input  rsdata_o, rtdata_o, rs_pending_o, rt_pending_o
    );
    modport slave (
        input  rsaddr_i, rtaddr_i, regwrite_i, writeaddr_i, writedata_i,
        input  alloc_i, allocaddr_i,
        output rsdata_o, rtdata_o, rs_pending_o, rt_pending_o
    );
`else
    modport master (
        output rsaddr_i, rtaddr_i, regwrite_i, writeaddr_i, writedata_i,
        input  rsdata_o, rtdata_o
    );
    modport slave (
        input  rsaddr_i, rtaddr_i, regwrite_i, writeaddr_i, writedata_i,
        output rsdata_o, rtdata_o
    );
`endif
endinterface

// File: rtl/regfile_sweep.sv
// rtl/regfile_sweep.sv - 2R/1W register file with clear sweep, bypass and zero register
// Optional pending scoreboard enabled by REGFILE_SCOREBOARD_EN.
module regfile_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    output logic            busy_o,
    regfile_sweep_if.slave  rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              idle;
    logic              wr_en;
    logic              rs_zero, rt_zero, wa_zero;
    logic              rs_fwd, rt_fwd;
    logic              rd_block;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == S_CLEAR);
    assign idle   = (state_q == S_IDLE);

    assign wa_zero = (ZERO_REG != 0) && (rf.writeaddr_i == '0);
    assign rs_zero = (ZERO_REG != 0) && (rf.rsaddr_i == '0);
    assign rt_zero = (ZERO_REG != 0) && (rf.rtaddr_i == '0);

    // A write is "performed" only in IDLE, outside reset, and not to a hard-wired zero entry.
    assign wr_en = idle && !rst_i && rf.regwrite_i && !wa_zero;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == S_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                mem_q[rf.writeaddr_i] <= rf.writedata_i;
            end
        end
    end

    assign rd_block = rst_i || (state_q == S_CLEAR);
    assign rs_fwd   = (BYPASS != 0) && wr_en && (rf.writeaddr_i == rf.rsaddr_i);
    assign rt_fwd   = (BYPASS != 0) && wr_en && (rf.writeaddr_i == rf.rtaddr_i);

    always_comb begin
        rf.rsdata_o = mem_q[rf.rsaddr_i];
        if (rd_block || rs_zero) begin
            rf.rsdata_o = '0;
        end else if (rs_fwd) begin
            rf.rsdata_o = rf.writedata_i;
        end
    end

    always_comb begin
        rf.rtdata_o = mem_q[rf.rtaddr_i];
        if (rd_block || rt_zero) begin
            rf.rtdata_o = '0;
        end else if (rt_fwd) begin
            rf.rtdata_o = rf.writedata_i;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] pending_q, pending_d;
    logic             aa_zero;

    assign aa_zero = (ZERO_REG != 0) && (rf.allocaddr_i == '0);

    // Write clears before alloc sets so a same-address collision leaves the entry pending.
    always_comb begin
        pending_d = pending_q;
        if (idle) begin
            if (wr_en) begin
                pending_d[rf.writeaddr_i] = 1'b0;
            end
            if (clear_i) begin
                pending_d = '0;
            end else if (rf.alloc_i && !aa_zero) begin
                pending_d[rf.allocaddr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rf.rs_pending_o = !rd_block && pending_q[rf.rsaddr_i];
    assign rf.rt_pending_o = !rd_block && pending_q[rf.rtaddr_i];
`endif
endmodule

// File: tb/tb_regfile_sweep.sv
// tb/tb_regfile_sweep.sv - bench for regfile_sweep (BYPASS=1 and BYPASS=0 instances)
module tb_regfile_sweep;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [ADDR_W-1:0] rs = '0, rt = '0, wa = '0, aa = '0;
    logic              we = 1'b0, alloc = 1'b0;
    logic [DATA_W-1:0] wd = '0;
    logic              busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    regfile_sweep_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    regfile_sweep_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.rsaddr_i = rs;    assign bus_b.rsaddr_i = rs;
    assign bus_a.rtaddr_i = rt;    assign bus_b.rtaddr_i = rt;
    assign bus_a.regwrite_i = we;  assign bus_b.regwrite_i = we;
    assign bus_a.writeaddr_i = wa; assign bus_b.writeaddr_i = wa;
    assign bus_a.writedata_i = wd; assign bus_b.writedata_i = wd;
`ifdef REGFILE_SCOREBOARD_EN
    assign bus_a.alloc_i = alloc;  assign bus_b.alloc_i = alloc;
    assign bus_a.allocaddr_i = aa; assign bus_b.allocaddr_i = aa;
`endif

    regfile_sweep #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy_a), .rf(bus_a));
    regfile_sweep #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy_b), .rf(bus_b));

    // Model: a sweep is a countdown; the whole array reads as zero once it ends.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_left = 0;
    logic [DEPTH-1:0]  m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = DEPTH;
            m_pend = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else begin
            if (we && wa != 0) begin
                m_mem[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (alloc && aa != 0) m_pend[aa] = 1'b1;
            if (clear) begin
                m_left = DEPTH;
                m_pend = '0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a, input bit byp);
        if (rst || m_left > 0 || a == 0) return '0;
        if (byp && we && wa == a) return wd;
        return m_mem[a];
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy_a", {31'b0, busy_a}, {31'b0, m_left > 0});
            chk("busy_b", {31'b0, busy_b}, {31'b0, m_left > 0});
            chk("rs_a", bus_a.rsdata_o, exp_rd(rs, 1'b1));
            chk("rt_a", bus_a.rtdata_o, exp_rd(rt, 1'b1));
            chk("rs_b", bus_b.rsdata_o, exp_rd(rs, 1'b0));
            chk("rt_b", bus_b.rtdata_o, exp_rd(rt, 1'b0));
`ifdef REGFILE_SCOREBOARD_EN
            chk("rs_pend", {31'b0, bus_a.rs_pending_o},
                {31'b0, !rst && m_left == 0 && m_pend[rs]});
            chk("rt_pend", {31'b0, bus_a.rt_pending_o},
                {31'b0, !rst && m_left == 0 && m_pend[rt]});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from now until busy drops; bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (!busy_a) return;
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        tick();
        check_en = 1'b1;
        tick();
        #2;
        chk("busy_in_reset", {31'b0, busy_a}, 32'd1);
        chk("rs_in_reset", bus_a.rsdata_o, 32'h0);
        rst = 1'b0;
        count_busy(n);
        chk("reset_sweep_len", n, 32'd32);
        tick();
        rs = 7;
        #2 chk("r7_after_reset", bus_a.rsdata_o, 32'h0);

        we = 1; wa = 5; wd = 32'hDEADBEEF;
        tick();
        we = 0; rs = 5; rt = 5;
        #2 chk("r5_rs", bus_a.rsdata_o, 32'hDEADBEEF);
        chk("r5_rt", bus_a.rtdata_o, 32'hDEADBEEF);

        we = 1; wa = 0; wd = 32'h1; rs = 0;
        #2 chk("r0_no_bypass", bus_a.rsdata_o, 32'h0);
        tick();
        we = 0;
        #2 chk("r0_stays_zero", bus_a.rsdata_o, 32'h0);

        we = 1; wa = 9; wd = 32'h12345678; rs = 9; rt = 9;
        #2 chk("bypass_rs", bus_a.rsdata_o, 32'h12345678);
        chk("bypass_rt", bus_a.rtdata_o, 32'h12345678);
        chk("nobypass_rs", bus_b.rsdata_o, 32'h0);
        tick();
        we = 0;
        #2 chk("nobypass_after", bus_b.rsdata_o, 32'h12345678);

        for (int i = 1; i < DEPTH; i++) begin
            we = 1; wa = ADDR_W'(i); wd = 32'hA5000000 | i;
            rs = ADDR_W'(i - 1); rt = ADDR_W'(i);
            tick();
        end
        we = 0; rs = 17;
        #2 chk("r17_filled", bus_a.rsdata_o, 32'hA5000011);

        clear = 1;
        tick();
        clear = 0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (!busy_a) break;
            n++;
            we = (i == 3); wa = 3; wd = 32'h55;
            tick();
        end
        we = 0;
        chk("clear_sweep_len", n, 32'd32);
        for (int i = 0; i < DEPTH; i++) begin
            rs = ADDR_W'(i); rt = ADDR_W'(DEPTH - 1 - i);
            #2 chk("post_clear_rs", bus_a.rsdata_o, 32'h0);
            chk("post_clear_rt", bus_a.rtdata_o, 32'h0);
            tick();
        end

        we = 1; wa = 12; wd = 32'hCAFE;
        tick();
        we = 0; clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        count_busy(n);
        chk("restart_sweep_len", n, 32'd32);
        rs = 12;
        #2 chk("r12_cleared", bus_a.rsdata_o, 32'h0);

        tick();
        clear = 1; we = 1; wa = 4; wd = 32'hAA; rs = 4;
        tick();
        clear = 0; we = 0;
        count_busy(n);
        chk("collision_sweep_len", n, 32'd32);
        chk("r4_after_collision", bus_a.rsdata_o, 32'h0);

`ifdef REGFILE_SCOREBOARD_EN
        tick();
        alloc = 1; aa = 6; rs = 6;
        tick();
        alloc = 0;
        #2 chk("pend_alloc6", {31'b0, bus_a.rs_pending_o}, 32'd1);
        we = 1; wa = 6; wd = 32'h66;
        tick();
        we = 0;
        #2 chk("pend_write6", {31'b0, bus_a.rs_pending_o}, 32'd0);
        alloc = 1; we = 1;
        tick();
        alloc = 0; we = 0;
        #2 chk("pend_collide6", {31'b0, bus_a.rs_pending_o}, 32'd1);
        alloc = 1; aa = 0; rs = 0;
        tick();
        alloc = 0;
        #2 chk("pend_alloc0", {31'b0, bus_a.rs_pending_o}, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            tick();
            rs = ADDR_W'($urandom); rt = ADDR_W'($urandom);
            we = ($urandom_range(0, 2) != 0);
            wa = ($urandom_range(0, 3) == 0) ? rs : ADDR_W'($urandom);
            wd = $urandom;
            alloc = $urandom_range(0, 1) == 1; aa = ADDR_W'($urandom);
            clear = ($urandom_range(0, 49) == 0);
        end
        tick();
        we = 0; clear = 0; alloc = 0;
        tick();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
